// File: rtl/sar_pkg.sv
// Shared constants and types for the SAR ADC sequencer/averager.
// Holds widths, the FSM state type and the burst-length helper.
package sar_pkg;

    localparam int ADC_W        = 8;
    localparam int OSR_MAX_LOG2 = 3;
    localparam int ACC_W        = ADC_W + OSR_MAX_LOG2;
    localparam int SCNT_W       = OSR_MAX_LOG2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Index of the last sample in a burst of 2**osr samples.
    function automatic logic [SCNT_W-1:0] last_idx(input logic [1:0] osr);
        logic [SCNT_W:0] n;
        n = ({{SCNT_W{1'b0}}, 1'b1} << osr) - 1'b1;
        return n[SCNT_W-1:0];
    endfunction

endpackage

// File: rtl/sar_tick_gen.sv
// Sample-period tick generator: one tick every period_i+1 cycles.
// Counter is parked at zero while disabled.
module sar_tick_gen #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                tick_o
);

    logic [PERIOD_W-1:0] cnt;
    logic                hit;

    assign hit    = (cnt == period_i);
    assign tick_o = en_i & hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (!en_i) begin
            cnt <= '0;
        end else if (hit) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sar_seq_avg.sv
// SAR ADC conversion sequencer with 1/2/4/8-sample averaging.
// Results leave on a valid/ready port; sticky overrun/timeout flags.
module sar_seq_avg
    import sar_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [1:0]          osr_i,
    output logic                start_o,
    input  logic                adc_rdy_i,
    input  logic [ADC_W-1:0]    adc_data_i,
    output logic [ADC_W-1:0]    data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                overrun_o,
    output logic                timeout_o,
    input  logic                clr_i
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_e            state;
    logic              tick;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  mean;
    logic [SCNT_W-1:0] scnt;
    logic [1:0]        osr_q;
    logic [TMR_W-1:0]  timer;
    logic              in_wait;
    logic              last;
    logic              pub;
    logic              to_evt;
    logic              ovr_evt;
    logic              take;

    sar_tick_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tick (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (en_i),
        .period_i (period_i),
        .tick_o   (tick)
    );

    assign in_wait = en_i & (state == WAIT);
    assign last    = (scnt == last_idx(osr_q));
    assign sum     = acc + ACC_W'(adc_data_i);
    assign mean    = sum >> osr_q;
    assign pub     = in_wait & adc_rdy_i & last;
    assign to_evt  = in_wait & ~adc_rdy_i & (timer == TMR_LAST);
    assign take    = ~valid_o | ready_i;
    assign ovr_evt = pub & ~take;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            start_o <= 1'b0;
            acc     <= '0;
            scnt    <= '0;
            osr_q   <= '0;
            timer   <= '0;
        end else begin
            start_o <= 1'b0;
            if (!en_i) begin
                state <= IDLE;
                acc   <= '0;
                scnt  <= '0;
                timer <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (tick) begin
                            state   <= WAIT;
                            start_o <= 1'b1;
                            timer   <= '0;
                            if (scnt == '0) begin
                                osr_q <= osr_i;
                            end
                        end
                    end
                    WAIT: begin
                        if (adc_rdy_i) begin
                            state <= IDLE;
                            if (last) begin
                                acc  <= '0;
                                scnt <= '0;
                            end else begin
                                acc  <= sum;
                                scnt <= scnt + 1'b1;
                            end
                        end else if (timer == TMR_LAST) begin
                            // Abandon the whole burst; partial sums are stale.
                            state <= IDLE;
                            acc   <= '0;
                            scnt  <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (pub) begin
            if (take) begin
                data_o  <= mean[ADC_W-1:0];
                valid_o <= 1'b1;
            end
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            if (ovr_evt) begin
                overrun_o <= 1'b1;
            end else if (clr_i) begin
                overrun_o <= 1'b0;
            end
            if (to_evt) begin
                timeout_o <= 1'b1;
            end else if (clr_i) begin
                timeout_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sar_seq_avg.sv
// Directed bench for sar_seq_avg with an ADC model and output scoreboard.
// Expected averages are queued up front and popped on each handshake.
module tb_sar_seq_avg;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic [15:0] period_i;
    logic [1:0]  osr_i;
    logic        start_o;
    logic        adc_rdy_i;
    logic [7:0]  adc_data_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic        overrun_o;
    logic        timeout_o;
    logic        clr_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    bit          adc_on;
    logic [7:0]  def_code;
    logic [7:0]  codes[$];
    logic [7:0]  sb[$];

    sar_seq_avg #(
        .PERIOD_W (16),
        .TIMEOUT  (16)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .period_i   (period_i),
        .osr_i      (osr_i),
        .start_o    (start_o),
        .adc_rdy_i  (adc_rdy_i),
        .adc_data_i (adc_data_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .overrun_o  (overrun_o),
        .timeout_o  (timeout_o),
        .clr_i      (clr_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // ADC: rdy one cycle, 9 cycles after the start_o cycle.
    initial begin
        adc_rdy_i  = 1'b0;
        adc_data_i = 8'h00;
        forever begin
            @(posedge clk_i);
            #1;
            if (start_o && adc_on) begin
                repeat (9) @(posedge clk_i);
                #1;
                adc_rdy_i  = 1'b1;
                adc_data_i = (codes.size() != 0) ? codes.pop_front() : def_code;
                @(posedge clk_i);
                #1;
                adc_rdy_i  = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
            if (sb.size() != 0) begin
                chk("sb_out", {24'h0, data_o}, {24'h0, sb.pop_front()});
            end else begin
                n_cmp++;
                assert (sb.size() != 0) else begin
                    n_bad++;
                    $error("FAIL unexpected_out: observed %0h expected none",
                           data_o);
                end
            end
        end
    end

    // which: 0 start_o, 1 timeout_o, 2 adc_rdy_i, 3 valid_o,
    //        4 scoreboard empty, 5 overrun_o
    task automatic wait_for(input int which, input string tag,
                            output int t);
        bit hit;
        hit = 1'b0;
        t   = -1;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk_i);
            case (which)
                0: hit = (start_o === 1'b1);
                1: hit = (timeout_o === 1'b1);
                2: hit = (adc_rdy_i === 1'b1);
                3: hit = (valid_o === 1'b1);
                4: hit = (sb.size() == 0);
                default: hit = (overrun_o === 1'b1);
            endcase
            if (hit) t = cyc;
        end
        if (!hit) begin
            n_cmp++;
            assert (hit) else begin
                n_bad++;
                $error("FAIL %s: observed no event expected event", tag);
            end
        end
    endtask

    initial begin
        int t1, t2, ts, tt, tx;
        rst_ni   = 1'b0;
        en_i     = 1'b0;
        period_i = 16'd10;
        osr_i    = 2'd0;
        ready_i  = 1'b1;
        clr_i    = 1'b0;
        adc_on   = 1'b1;
        def_code = 8'hA5;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_start", {31'h0, start_o}, 32'h0);
        chk("rst_data", {24'h0, data_o}, 32'h0);
        chk("rst_valid", {31'h0, valid_o}, 32'h0);
        chk("rst_ovr", {31'h0, overrun_o}, 32'h0);
        chk("rst_to", {31'h0, timeout_o}, 32'h0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("idle_start", {31'h0, start_o}, 32'h0);

        // osr=0, period=10: one A5 result per conversion
        repeat (3) sb.push_back(8'hA5);
        en_i = 1'b1;
        wait_for(0, "t1_start1", t1);
        wait_for(0, "t1_start2", t2);
        chk("t1_spacing", t2 - t1, 11);
        wait_for(4, "t1_drain", tx);
        en_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("t1_valid_low", {31'h0, valid_o}, 32'h0);
        chk("t1_data_hold", {24'h0, data_o}, 32'hA5);
        repeat (15) @(negedge clk_i);

        // osr=3: eight codes average to 360>>3
        osr_i = 2'd3;
        for (int i = 1; i <= 8; i++) codes.push_back(8'(10 * i));
        sb.push_back(8'h2D);
        en_i = 1'b1;
        wait_for(4, "t2_drain", tx);
        en_i = 1'b0;
        repeat (15) @(negedge clk_i);
        chk("t2_codes_used", codes.size(), 0);

        // backpressure: second result dropped, overrun set
        osr_i   = 2'd0;
        ready_i = 1'b0;
        def_code = 8'h33;
        codes.push_back(8'h11);
        codes.push_back(8'h22);
        sb.push_back(8'h11);
        en_i = 1'b1;
        wait_for(5, "t3_overrun", tx);
        en_i = 1'b0;
        @(negedge clk_i);
        chk("t3_data_kept", {24'h0, data_o}, 32'h11);
        chk("t3_valid", {31'h0, valid_o}, 32'h1);
        chk("t3_ovr", {31'h0, overrun_o}, 32'h1);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        chk("t3_ovr_clr", {31'h0, overrun_o}, 32'h0);
        ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("t3_valid_drop", {31'h0, valid_o}, 32'h0);
        chk("t3_sb_empty", sb.size(), 0);
        repeat (15) @(negedge clk_i);

        // timeout mid-burst, then a fresh burst from a cleared acc
        osr_i = 2'd1;
        codes.push_back(8'h10);
        en_i = 1'b1;
        wait_for(2, "t4_rdy1", tx);
        adc_on = 1'b0;
        wait_for(0, "t4_start", ts);
        wait_for(1, "t4_timeout", tt);
        chk("t4_to_delay", tt - ts, 16);
        chk("t4_no_out", {31'h0, valid_o}, 32'h0);
        adc_on = 1'b1;
        codes.push_back(8'h20);
        codes.push_back(8'h40);
        sb.push_back(8'h30);
        wait_for(4, "t4_drain", tx);
        en_i = 1'b0;
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        chk("t4_to_clr", {31'h0, timeout_o}, 32'h0);
        repeat (15) @(negedge clk_i);

        // short period: ticks in WAIT are dropped, spacing 12
        osr_i    = 2'd0;
        period_i = 16'd3;
        def_code = 8'h77;
        sb.push_back(8'h77);
        en_i = 1'b1;
        wait_for(0, "t5_start1", t1);
        wait_for(0, "t5_start2", t2);
        en_i = 1'b0;
        chk("t5_spacing", t2 - t1, 12);
        repeat (15) @(negedge clk_i);
        chk("t5_sb_empty", sb.size(), 0);

        // disable after 2 of 4 samples, then 4 fresh samples
        osr_i    = 2'd2;
        period_i = 16'd10;
        codes.push_back(8'd1);
        codes.push_back(8'd2);
        en_i = 1'b1;
        wait_for(2, "t6_rdy1", tx);
        wait_for(2, "t6_rdy2", tx);
        @(negedge clk_i);
        en_i = 1'b0;
        repeat (15) @(negedge clk_i);
        chk("t6_no_out", {31'h0, valid_o}, 32'h0);
        codes.push_back(8'd4);
        codes.push_back(8'd8);
        codes.push_back(8'd12);
        codes.push_back(8'd16);
        sb.push_back(8'h0A);
        en_i = 1'b1;
        wait_for(4, "t6_drain", tx);
        en_i = 1'b0;
        repeat (15) @(negedge clk_i);

        // async reset while a conversion is pending
        osr_i    = 2'd0;
        ready_i  = 1'b0;
        def_code = 8'h55;
        en_i = 1'b1;
        wait_for(3, "t7_valid", tx);
        wait_for(0, "t7_start", tx);
        repeat (3) @(negedge clk_i);
        chk("t7_pre_data", {24'h0, data_o}, 32'h55);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t7_rst_start", {31'h0, start_o}, 32'h0);
        chk("t7_rst_data", {24'h0, data_o}, 32'h0);
        chk("t7_rst_valid", {31'h0, valid_o}, 32'h0);
        chk("t7_rst_ovr", {31'h0, overrun_o}, 32'h0);
        chk("t7_rst_to", {31'h0, timeout_o}, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        wait_for(0, "t7_restart", tx);
        en_i = 1'b0;
        ready_i = 1'b1;
        repeat (15) @(negedge clk_i);
        chk("final_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
